// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_pkg
//  Description : Shared constants and types for the HyperBus transfer
//                scheduler: request descriptor, FSM state, chunk command.
//  Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned NUM_CHIPS       = 2;
    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned LEN_WIDTH       = 16;
    localparam int unsigned MAX_BURST_WORDS = 256;
    localparam int unsigned ROW_BYTES       = 2048;
    localparam int unsigned CHIP_SIZE_BYTES = 2 ** 23;

    // Owner index width; a single requester still needs one bit.
    localparam int unsigned OWNER_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so that len = all-ones (2**LEN_WIDTH words) fits.
    localparam int unsigned REM_WIDTH   = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [REM_WIDTH-1:0]   remaining;
        logic                   write;
        logic [OWNER_WIDTH-1:0] owner;
    } sched_desc_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  write;
        logic [NUM_CHIPS-1:0]  cs;
        logic                  last;
    } chunk_cmd_t;

    // Smaller of two word counts.
    function automatic logic [REM_WIDTH-1:0] min_words(input logic [REM_WIDTH-1:0] a,
                                                       input logic [REM_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage : hyperbus_pkg
`default_nettype wire

// File: rtl/hyper_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hyper_rr_arbiter
//  Description : Round-robin picker. Grants the first asserted request
//                strictly after the pointer position, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module hyper_rr_arbiter #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = 1
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] grant_idx,
    output logic                any_valid
);

    logic found;

    // Walk ptr+1 .. ptr+NumReq (mod NumReq); first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        any_valid = |req;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            logic [IdxWidth-1:0] cand;
            cand = IdxWidth'((32'(ptr) + i) % NumReq);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule : hyper_rr_arbiter
`default_nettype wire

// File: rtl/hyper_trans_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hyper_trans_scheduler
//  Description : Arbitrates requesters onto the HyperBus PHY command channel,
//                splitting each request into chunks bounded by the burst cap
//                and row boundaries, deriving chip select from the address.
//  Revision    : 1.0 - initial release
// ============================================================================
module hyper_trans_scheduler
    import hyperbus_pkg::*;
#(
    // Shared struct types are sized from hyperbus_pkg; keep these equal to it.
    parameter int unsigned NumReq        = NUM_REQ,
    parameter int unsigned NumChips      = NUM_CHIPS,
    parameter int unsigned AddrWidth     = ADDR_WIDTH,
    parameter int unsigned LenWidth      = LEN_WIDTH,
    parameter int unsigned MaxBurstWords = MAX_BURST_WORDS,
    parameter int unsigned RowBytes      = ROW_BYTES,
    parameter int unsigned ChipSizeBytes = CHIP_SIZE_BYTES
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [LenWidth-1:0]              cfg_max_burst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0][LenWidth-1:0]  req_len_i,
    input  logic [NumReq-1:0]                req_write_i,
    output logic [NumReq-1:0]                req_done_o,
    output logic                             trans_valid_o,
    input  logic                             trans_ready_i,
    output logic [AddrWidth-1:0]             trans_addr_o,
    output logic [LenWidth-1:0]              trans_len_o,
    output logic                             trans_write_o,
    output logic [NumChips-1:0]              trans_cs_o,
    output logic                             trans_last_o,
    input  logic                             trans_done_i,
    output logic                             busy_o
);

    localparam int unsigned ChipBits = $clog2(ChipSizeBytes);
    localparam int unsigned RowBits  = $clog2(RowBytes);
    localparam int unsigned RowWords = RowBytes / 2;
    localparam int unsigned CsBits   = (NumChips > 1) ? $clog2(NumChips) : 1;

    sched_state_e state, state_next;
    sched_desc_t  desc;
    chunk_cmd_t   cmd, cmd_next;

    logic [OWNER_WIDTH-1:0] rr_ptr;
    logic [NumReq-1:0]      grant;
    logic [OWNER_WIDTH-1:0] grant_idx;
    logic                   any_valid;

    logic                   load, advance, reissue;
    logic [AddrWidth-1:0]   src_addr;
    logic [REM_WIDTH-1:0]   src_rem;
    logic                   src_write;
    logic [RowBits-2:0]     row_off_words;
    logic [REM_WIDTH-1:0]   row_left, cap, cfg_words, chunk, cmd_words;
    logic [CsBits-1:0]      cs_idx;

    hyper_rr_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (OWNER_WIDTH)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign load    = (state == IDLE)  && any_valid;
    assign advance = (state == ISSUE) && trans_ready_i;
    assign reissue = (state == WAIT)  && trans_done_i && (desc.remaining != '0);

    // Chunk source: the newly granted request, or the in-flight descriptor.
    always_comb begin
        src_addr  = desc.addr;
        src_rem   = desc.remaining;
        src_write = desc.write;
        if (load) begin
            src_addr  = {req_addr_i[grant_idx][AddrWidth-1:1], 1'b0};
            src_rem   = REM_WIDTH'(req_len_i[grant_idx]) + REM_WIDTH'(1);
            src_write = req_write_i[grant_idx];
        end
    end

    // Chunk size = min(remaining, burst cap, words left in the current row).
    always_comb begin
        row_off_words = src_addr[RowBits-1:1];
        row_left      = REM_WIDTH'(RowWords) - REM_WIDTH'(row_off_words);
        cfg_words     = REM_WIDTH'(cfg_max_burst_i);
        cap           = REM_WIDTH'(MaxBurstWords);
        if ((cfg_max_burst_i != '0) && (cfg_words < cap)) begin
            cap = cfg_words;
        end
        chunk = min_words(min_words(src_rem, cap), row_left);
    end

    if (NumChips > 1) begin : g_cs_multi
        assign cs_idx = src_addr[ChipBits +: CsBits];
    end else begin : g_cs_single
        assign cs_idx = '0;
    end

    // Assemble the next chunk command from the source and computed size.
    always_comb begin
        cmd_next       = '0;
        cmd_next.addr  = AddrWidth'(src_addr[ChipBits-1:0]);
        cmd_next.len   = LenWidth'(chunk - REM_WIDTH'(1));
        cmd_next.write = src_write;
        cmd_next.last  = (chunk == src_rem);
        for (int unsigned c = 0; c < NumChips; c++) begin
            cmd_next.cs[c] = (cs_idx == CsBits'(c));
        end
    end

    // Words carried by the chunk currently registered in cmd.
    assign cmd_words = REM_WIDTH'(cmd.len) + REM_WIDTH'(1);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_valid)     state_next = ISSUE;
            ISSUE:   if (trans_ready_i) state_next = WAIT;
            WAIT: begin
                if (trans_done_i) begin
                    state_next = (desc.remaining == '0) ? IDLE : ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Descriptor, chunk command and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            desc   <= '0;
            cmd    <= '0;
            rr_ptr <= OWNER_WIDTH'(NumReq - 1);
        end else if (load) begin
            desc.addr      <= src_addr;
            desc.remaining <= src_rem;
            desc.write     <= src_write;
            desc.owner     <= grant_idx;
            rr_ptr         <= grant_idx;
            cmd            <= cmd_next;
        end else if (advance) begin
            desc.addr      <= desc.addr + AddrWidth'({cmd_words, 1'b0});
            desc.remaining <= desc.remaining - cmd_words;
        end else if (reissue) begin
            cmd            <= cmd_next;
        end
    end

    // FSM outputs: handshakes and completion pulse.
    always_comb begin
        trans_valid_o = (state == ISSUE);
        busy_o        = (state != IDLE);
        req_ready_o   = load ? grant : '0;
        req_done_o    = '0;
        if ((state == WAIT) && trans_done_i && (desc.remaining == '0)) begin
            req_done_o[desc.owner] = 1'b1;
        end
    end

    assign trans_addr_o  = cmd.addr;
    assign trans_len_o   = cmd.len;
    assign trans_write_o = cmd.write;
    assign trans_cs_o    = cmd.cs;
    assign trans_last_o  = cmd.last;

endmodule : hyper_trans_scheduler
`default_nettype wire
